// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction-fetch sequencer and its neighbours
// (IR, ROM models).
//   - FSM state encodings IDLE / REQ / LOAD
//   - default address and data widths
//   - timeout counter width (covers TIMEOUT values 1..255)
// -----------------------------------------------------------------------------
package fetch_pkg;

    localparam int DEF_ADDR_W = 13;
    localparam int DEF_DATA_W = 16;
    localparam int CNT_W      = 8;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] LOAD = 2'd2;

endpackage : fetch_pkg

// File: rtl/pc_counter.sv
// -----------------------------------------------------------------------------
// pc_counter
// Program counter register with jump load and increment.
// Load has priority over increment. The increment wraps modulo 2^ADDR_W.
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous active-high reset (PC <= RESET_PC)
//   i_load     in   load PC from i_load_val
//   i_load_val in   jump target
//   i_inc      in   advance PC by one
//   o_pc       out  current program counter (registered)
// -----------------------------------------------------------------------------
module pc_counter
    import fetch_pkg::*;
#(
    parameter int                 ADDR_W   = DEF_ADDR_W,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [ADDR_W-1:0] i_load_val,
    input  logic              i_inc,
    output logic [ADDR_W-1:0] o_pc
);

    logic [ADDR_W-1:0] r_pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else if (i_load) begin
            r_pc <= i_load_val;
        end else if (i_inc) begin
            r_pc <= r_pc + ADDR_W'(1);
        end
    end

    assign o_pc = r_pc;

endmodule : pc_counter

// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl
// Instruction-fetch sequencer. Issues one ROM read per accepted fetch_req,
// waits for a variable-latency ack (bounded by TIMEOUT), captures the word
// into ir_data and strobes load_ir / fetch_done for one cycle, then advances
// the PC.
//
// Memory handshake: rom_rd is a level request; rom_addr is stable for as long
// as rom_rd is high. The transfer completes in the first cycle where
// rom_rd && rom_ack are both high, and rom_rdata is sampled in that cycle.
// If no ack arrives within TIMEOUT request cycles, rom_rd is withdrawn and
// fetch_err pulses. An ack seen while rom_rd is low is ignored.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   fetch_req       fetch one instruction (sampled in IDLE only)
//   halt            suppress new fetches (does not abort an in-flight one)
//   pc_load/_val    jump: load PC next edge (any state, beats increment)
//   rom_addr/rom_rd read request to program memory
//   rom_rdata/ack   read data / completion strobe
//   ir_data/load_ir captured word and one-cycle IR load strobe
//   fetch_done      one-cycle pulse together with load_ir
//   fetch_err       one-cycle pulse on timeout abort
//   pc              current program counter
//   busy            state != IDLE
//   dbg_state       current FSM state encoding
// -----------------------------------------------------------------------------
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int                 ADDR_W   = DEF_ADDR_W,
    parameter int                 DATA_W   = DEF_DATA_W,
    parameter int                 TIMEOUT  = 15,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_req,
    input  logic              halt,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_load_val,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_rd,
    input  logic [DATA_W-1:0] rom_rdata,
    input  logic              rom_ack,
    output logic [DATA_W-1:0] ir_data,
    output logic              load_ir,
    output logic              fetch_done,
    output logic              fetch_err,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic [1:0]        dbg_state
);

    // Last counter value before abort: TIMEOUT request cycles in total.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_rom_addr;
    logic              r_rom_rd;
    logic [DATA_W-1:0] r_ir_data;
    logic              r_load_ir;
    logic              r_fetch_done;
    logic              r_fetch_err;
    logic              r_busy;
    logic [ADDR_W-1:0] w_pc;
    logic              w_pc_inc;

    // PC advances on the edge that leaves LOAD; a simultaneous jump wins.
    assign w_pc_inc = (r_state == LOAD);

    pc_counter #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc_counter (
        .clk        (clk),
        .rst        (rst),
        .i_load     (pc_load),
        .i_load_val (pc_load_val),
        .i_inc      (w_pc_inc),
        .o_pc       (w_pc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_rom_addr   <= '0;
            r_rom_rd     <= 1'b0;
            r_ir_data    <= '0;
            r_load_ir    <= 1'b0;
            r_fetch_done <= 1'b0;
            r_fetch_err  <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            // Strobes default low so each lasts exactly one cycle.
            r_load_ir    <= 1'b0;
            r_fetch_done <= 1'b0;
            r_fetch_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    // A request under halt is dropped, not remembered.
                    if (fetch_req && !halt) begin
                        r_rom_addr <= w_pc;
                        r_rom_rd   <= 1'b1;
                        r_cnt      <= '0;
                        r_state    <= REQ;
                        r_busy     <= 1'b1;
                    end
                end
                REQ: begin
                    // An ack on the final allowed cycle still completes.
                    if (rom_ack) begin
                        r_ir_data    <= rom_rdata;
                        r_rom_rd     <= 1'b0;
                        r_load_ir    <= 1'b1;
                        r_fetch_done <= 1'b1;
                        r_state      <= LOAD;
                    end else if (r_cnt == CNT_LAST) begin
                        r_rom_rd    <= 1'b0;
                        r_fetch_err <= 1'b1;
                        r_state     <= IDLE;
                        r_busy      <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                LOAD: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state  <= IDLE;
                    r_rom_rd <= 1'b0;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

    assign rom_addr   = r_rom_addr;
    assign rom_rd     = r_rom_rd;
    assign ir_data    = r_ir_data;
    assign load_ir    = r_load_ir;
    assign fetch_done = r_fetch_done;
    assign fetch_err  = r_fetch_err;
    assign pc         = w_pc;
    assign busy       = r_busy;
    assign dbg_state  = r_state;

endmodule : fetch_ctrl
